// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and widths for the FourBitALU datapath
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int STEP_W = 2;

endpackage

// File: rtl/mul4_shift_add_if.sv
// rtl/mul4_shift_add_if.sv - start/done handshake bundle for the sequential multiplier
interface mul4_shift_add_if;
  import alu_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              ready;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);

endinterface

// File: rtl/fourbitFA.sv
// rtl/fourbitFA.sv - 4-bit ripple-carry adder, carry-in tied low
module fourbitFA
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] sum,
  output logic            carry
);

  logic [OP_W:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    for (int i = 0; i < OP_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[OP_W];
  end

endmodule

// File: rtl/mul4_shift_add.sv
// rtl/mul4_shift_add.sv - 4x4 unsigned shift-and-add multiplier, one partial product per cycle
module mul4_shift_add
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mul4_shift_add_if.slave  bus
);

  mul_state_t        state;
  logic [OP_W-1:0]   acc;
  logic [OP_W-1:0]   q;
  logic [OP_W-1:0]   m;
  logic [STEP_W-1:0] step;
  logic [PROD_W-1:0] product_q;

  logic [OP_W-1:0]   addend;
  logic [OP_W-1:0]   sum;
  logic              carry;
  logic [PROD_W-1:0] shifted;

  assign addend  = q[0] ? m : '0;
  // Carry, sum and the surviving multiplier bits form the next {acc, q}.
  assign shifted = {carry, sum, q[OP_W-1:1]};

  fourbitFA u_adder (
    .a     (acc),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      step      <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m     <= bus.a;
            q     <= bus.b;
            acc   <= '0;
            step  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          {acc, q} <= shifted;
          step     <= step + 2'd1;
          if (step == 2'd3) begin
            product_q <= shifted;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready   = (state != RUN);
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule

// File: doc/mul4_shift_add.md
# mul4_shift_add

Sequential 4x4 unsigned shift-and-add multiplier for the FourBitALU datapath. Each step drives the 4-bit ripple adder's operands and registers its sum and carry-out. An 8-bit product is produced in a fixed 4-step sequence under a start/done handshake. Results are held in an output register for downstream ALU result muxing.

## Interface
- No parameters. Operand width is fixed at 4 bits by the adder; the product is 8 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to multiply `a` by `b`; sampled only while `ready`=1.
- a  input  4  multiplicand, unsigned.
- b  input  4  multiplier, unsigned.
- ready  output  1  block accepts `start` this cycle; equals (state != RUN).
- busy  output  1  multiplication in progress; equals (state == RUN).
- done  output  1  single-cycle pulse; `product` has just been updated.
- product  output  8  last completed result; held until the next completion.

## Operation
- FSM states:
  - IDLE: go to RUN on `start`; otherwise stay.
  - RUN: stay for exactly 4 cycles, then go to DONE.
  - DONE: one cycle; go to RUN on `start`, otherwise go to IDLE.
- On accepted `start`:
  - M <= a, Q <= b, A <= 0, step <= 0.
  - `a`/`b` are not sampled again until the next accepted start.
- Each RUN cycle:
  - Adder operands are A and (Q[0] ? M : 4'b0).
  - Adder result is {C, S}.
  - {A, Q} <= {C, S, Q[3:1]} (9-bit value shifted right by one).
  - step <= step + 1.
  - On step == 3, go to DONE and load product <= {C, S, Q[3:1]} (8 bits).
- Arithmetic:
  - Unsigned only.
  - 15x15 = 225 fits in 8 bits; no overflow is possible.
  - The adder carry-in is always 0.
- `start` while busy is ignored, with no queuing and no error flag.
- `start` in DONE is accepted: the next RUN begins in the following cycle, so back-to-back operation gives a throughput of one result per 5 cycles.
- `product` changes only on the transition RUN->DONE (and on reset). During RUN it still shows the previous result.
- Reset at any time (including mid-RUN):
  - state = IDLE, product = 0, done = 0, busy = 0, ready = 1.
  - A, Q, M and step are cleared.
  - The partial result is discarded and no `done` pulse is issued.

## Timing
- Reset values: ready = 1, busy = 0, done = 0, product = 8'h00.
- Latency: `start` is sampled at edge k. `busy` is high in the cycles after edges k..k+3. `done` is high and the new `product` is visible in the cycle after edge k+4.
- `done` is high for exactly one cycle per accepted start.
- All outputs are registered or decoded from state only. There is no combinational path from `start`, `a` or `b` to any output.
- Reset deassertion is assumed synchronous to `clk` upstream. The first operation can be accepted on the first edge after deassertion.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t`.
  - `localparam OP_W = 4`, `PROD_W = 8`, `STEP_W = 2`.
- One sub-module instance: the existing 4-bit ripple adder `fourbitFA`, with ports a, b, sum and carry.
  - Its `a` is driven by A, its `b` by the gated M.
  - Its sum and carry feed the shift register.
  - No other arithmetic operators in this block except the 2-bit step counter increment.

## Test plan
- Reset, then start with a=4'hF, b=4'hF: done pulses exactly 5 cycles after start; product = 8'hE1; busy high for 4 cycles.
- a=4'h9, b=4'h6 -> product = 8'h36. Then a=4'h0, b=4'hB -> product = 8'h00. Then a=4'h1, b=4'h1 -> product = 8'h01.
- Start with a=3, b=5, then assert start with a=7, b=7 during RUN: the second start is ignored; product = 8'h0F; a single done pulse.
- Back-to-back: start held high with a=2, b=3, changed to a=4, b=4 in the DONE cycle:
  - product = 8'h06, then 8'h10.
  - done pulses are 5 cycles apart.
  - ready = 0 only during RUN.
- Start a=F, b=F, assert rst in the 2nd RUN cycle: all outputs return to reset values immediately (asynchronously); no done pulse. A subsequent start with a=2, b=2 gives product = 8'h04.
- Exhaustive sweep of all 256 a/b pairs against the a*b reference model: every product matches and every latency is 5 cycles.
